// File: rtl/sram_fetch_sequencer_pkg.sv
// Shared types and constants for the SRAM fetch sequencer and its watchdog.
package nn_sram_pkg;

    localparam int   SEL_W      = 7;
    localparam int   BYTE_CNT_W = 16;
    localparam logic N_IMAGE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IMG_REQ,
        ST_IMG_WAIT,
        ST_COEF_RDY,
        ST_COEF_REQ,
        ST_COEF_WAIT,
        ST_DONE,
        ST_ERR
    } fetch_state_t;

    function automatic logic is_wait(input fetch_state_t s);
        return (s == ST_IMG_WAIT) || (s == ST_COEF_WAIT);
    endfunction

endpackage

// File: rtl/sram_fetch_sequencer_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT_CYC-th consecutive enabled cycle without a clear.
module sram_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    // cnt_q holds (enabled cycles elapsed - 1), so LAST marks the final allowed cycle
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/sram_fetch_sequencer.sv
// Pass sequencer for the SRAM timer: one image fetch, then one coefficient fetch per node.
// Handshake: start_sram is a one-cycle launch; the fetch is complete on the sram_done pulse.
module sram_fetch_sequencer #(
    parameter int NUM_NODES   = 100,
    parameter int SEL_W       = nn_sram_pkg::SEL_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               go,
    input  logic                               abort,
    input  logic                               node_ready,
    input  logic                               sram_done,
    input  logic                               read_nxt_byte,
    output logic                               start_sram,
    output logic [SEL_W-1:0]                   coef_select,
    output logic                               n_coef_image,
    output logic                               busy,
    output logic                               pass_done,
    output logic                               timeout_err,
    output logic [nn_sram_pkg::BYTE_CNT_W-1:0] byte_count,
    output nn_sram_pkg::fetch_state_t          dbg_state
);
    import nn_sram_pkg::*;

    localparam logic [SEL_W-1:0] LAST_K = SEL_W'(NUM_NODES - 1);

    fetch_state_t          state_q;
    logic [SEL_W-1:0]      k_q;
    logic [SEL_W-1:0]      coef_select_q;
    logic                  start_sram_q;
    logic                  n_coef_image_q;
    logic                  busy_q;
    logic                  pass_done_q;
    logic                  timeout_err_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  in_wait;
    logic                  wd_clear;
    logic                  wd_expired;

    assign in_wait  = is_wait(state_q);
    // REQ always precedes a WAIT, so clearing there restarts the count on entry
    assign wd_clear = (state_q == ST_IMG_REQ) || (state_q == ST_COEF_REQ) ||
                      (in_wait && read_nxt_byte);

    sram_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (in_wait),
        .expired (wd_expired)
    );

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (in_wait && read_nxt_byte && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            k_q            <= '0;
            coef_select_q  <= '0;
            start_sram_q   <= 1'b0;
            n_coef_image_q <= 1'b0;
            busy_q         <= 1'b0;
            pass_done_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            byte_cnt_q     <= '0;
        end else begin
            start_sram_q <= 1'b0;
            pass_done_q  <= 1'b0;
            if (abort) begin
                state_q        <= ST_IDLE;
                busy_q         <= 1'b0;
                coef_select_q  <= '0;
                n_coef_image_q <= 1'b0;
            end else begin
                byte_cnt_q <= byte_cnt_d;
                case (state_q)
                    ST_IDLE, ST_ERR: begin
                        if (go) begin
                            state_q        <= ST_IMG_REQ;
                            start_sram_q   <= 1'b1;
                            n_coef_image_q <= N_IMAGE;
                            coef_select_q  <= '0;
                            busy_q         <= 1'b1;
                            byte_cnt_q     <= '0;
                            timeout_err_q  <= 1'b0;
                            k_q            <= '0;
                        end
                    end
                    ST_IMG_REQ:  state_q <= ST_IMG_WAIT;
                    ST_IMG_WAIT: begin
                        if (wd_expired) begin
                            state_q       <= ST_ERR;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                        end else if (sram_done) begin
                            state_q <= ST_COEF_RDY;
                        end
                    end
                    ST_COEF_RDY: begin
                        if (node_ready) begin
                            state_q        <= ST_COEF_REQ;
                            start_sram_q   <= 1'b1;
                            n_coef_image_q <= ~N_IMAGE;
                            coef_select_q  <= k_q;
                        end
                    end
                    ST_COEF_REQ: state_q <= ST_COEF_WAIT;
                    ST_COEF_WAIT: begin
                        if (wd_expired) begin
                            state_q       <= ST_ERR;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                        end else if (sram_done) begin
                            if (k_q == LAST_K) begin
                                state_q     <= ST_DONE;
                                pass_done_q <= 1'b1;
                            end else begin
                                k_q     <= k_q + 1'b1;
                                state_q <= ST_COEF_RDY;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q        <= ST_IDLE;
                        busy_q         <= 1'b0;
                        coef_select_q  <= '0;
                        n_coef_image_q <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign start_sram   = start_sram_q;
    assign coef_select  = coef_select_q;
    assign n_coef_image = n_coef_image_q;
    assign busy         = busy_q;
    assign pass_done    = pass_done_q;
    assign timeout_err  = timeout_err_q;
    assign byte_count   = byte_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sram_fetch_sequencer.sv
// Bench for sram_fetch_sequencer: directed vector table, hand-written corner sequences,
// and randomized passes against a fetch-level model with a behavioural SRAM timer.
module tb_sram_fetch_sequencer;
    import nn_sram_pkg::*;

    localparam int NUM_NODES = 3;
    localparam int TIMEOUT   = 16;

    logic         clk = 1'b0;
    logic         rst, go, abort, node_ready, sram_done, read_nxt_byte;
    logic         start_sram, n_coef_image, busy, pass_done, timeout_err;
    logic [6:0]   coef_select;
    logic [15:0]  byte_count;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    sram_fetch_sequencer #(.NUM_NODES(NUM_NODES), .SEL_W(7), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .abort         (abort),
        .node_ready    (node_ready),
        .sram_done     (sram_done),
        .read_nxt_byte (read_nxt_byte),
        .start_sram    (start_sram),
        .coef_select   (coef_select),
        .n_coef_image  (n_coef_image),
        .busy          (busy),
        .pass_done     (pass_done),
        .timeout_err   (timeout_err),
        .byte_count    (byte_count),
        .dbg_state     (dbg_state)
    );

    typedef struct {
        logic         go, abort, nr, sd, rnb;
        logic         st, nci;
        logic [6:0]   sel;
        logic         bsy, pd;
        logic [15:0]  bc;
        fetch_state_t state;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         checks = 0, errors = 0, cyc = 0;
    int         start_cyc[16];
    int         fetch_no, stall_at, pd_cnt, pd_cyc, bytes_sent, done_cnt, stall_bytes;
    bit         tm_active, tm_stall, rand_mode, spurious_en;
    int         tm_cyc, tm_lat, tm_bytes;
    logic       nr_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, start_sram, n_coef_image, coef_select, busy, pass_done,
                timeout_err, byte_count, dbg_state};
    endfunction

    function automatic logic [7:0] req(input logic img, input int k);
        return {img, 7'(k)};
    endfunction

    task automatic add_vec(input logic g, ab, nr, sd, rnb, st, nci, input int sel,
                           input logic bsy, pd, input int bc, input fetch_state_t s);
        vec_t v;
        v.go = g; v.abort = ab; v.nr = nr; v.sd = sd; v.rnb = rnb;
        v.st = st; v.nci = nci; v.sel = 7'(sel); v.bsy = bsy; v.pd = pd;
        v.bc = 16'(bc); v.state = s;
        tbl.push_back(v);
    endtask

    // Fetch-level model: image first, then nodes 0..N-1, cut short at a stalled fetch.
    task automatic load_pass(input int last_fetch);
        exp_q.delete();
        for (int f = 0; f <= last_fetch; f++)
            exp_q.push_back(f == 0 ? req(1'b1, 0) : req(1'b0, f - 1));
        fetch_no = 0; pd_cnt = 0; pd_cyc = -1; bytes_sent = 0; done_cnt = 0;
        tm_active = 0; stall_bytes = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0; node_ready = 1'b0;
        sram_done = 1'b0; read_nxt_byte = 1'b0; tm_active = 0; stall_at = -1;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
    endtask

    // SRAM timer: bytes in wait cycles 1..tm_bytes, sram_done in wait cycle tm_lat.
    task automatic timer_step();
        sram_done = 1'b0;
        read_nxt_byte = 1'b0;
        if (tm_active) begin
            tm_cyc++;
            if (tm_cyc <= tm_bytes) begin
                read_nxt_byte = 1'b1;
                bytes_sent++;
            end
            if (!tm_stall && tm_cyc == tm_lat) begin
                sram_done = 1'b1;
                tm_active = 0;
                done_cnt++;
            end
        end else if (spurious_en) begin
            sram_done     = ($urandom_range(0, 3) == 0);
            read_nxt_byte = ($urandom_range(0, 3) == 0);
        end
        if (start_sram) begin
            tm_active = 1; tm_cyc = 0;
            tm_stall = (fetch_no == stall_at);
            if (rand_mode) begin
                tm_lat   = int'($urandom_range(1, 8));
                tm_bytes = int'($urandom_range(0, tm_lat));
            end else begin
                tm_lat   = 5;
                tm_bytes = tm_stall ? 0 : 4;
            end
            if (tm_stall) stall_bytes = tm_bytes;
            if (fetch_no < 16) start_cyc[fetch_no] = cyc;
            fetch_no++;
        end
    endtask

    task automatic cycle();
        logic [7:0] e;
        nr_prev = node_ready;
        @(posedge clk); #1; cyc++;
        if (start_sram) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_start: got start_sram=1 sel=%0d expected no request (cycle %0d)",
                         coef_select, cyc);
            end else begin
                e = exp_q.pop_front();
                check("fetch_request", {n_coef_image, coef_select}, e);
            end
            if (!n_coef_image) check("node_ready_before_req", nr_prev, 1'b1);
        end
        if (pass_done) begin
            pd_cnt++;
            pd_cyc = cyc;
        end
        timer_step();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        check("pass_ends_in_budget", busy, 1'b0);
    endtask

    initial begin
        int n, t0, s, sa;
        rand_mode = 0; spurious_en = 0;
        //       go ab nr sd rnb  st nci sel bsy pd  bc  state
        add_vec(0, 0, 0, 1, 1,   0, 0, 0,  0,  0,  0, ST_IDLE);
        add_vec(1, 0, 0, 0, 0,   1, 1, 0,  1,  0,  0, ST_IMG_REQ);
        add_vec(1, 0, 0, 0, 0,   0, 1, 0,  1,  0,  0, ST_IMG_WAIT);
        add_vec(0, 0, 0, 0, 1,   0, 1, 0,  1,  0,  1, ST_IMG_WAIT);
        add_vec(0, 0, 0, 1, 1,   0, 1, 0,  1,  0,  2, ST_COEF_RDY);
        add_vec(0, 0, 0, 1, 1,   0, 1, 0,  1,  0,  2, ST_COEF_RDY);
        add_vec(0, 0, 1, 0, 0,   1, 0, 0,  1,  0,  2, ST_COEF_REQ);
        add_vec(0, 0, 1, 1, 0,   0, 0, 0,  1,  0,  2, ST_COEF_WAIT);
        add_vec(0, 0, 0, 1, 1,   0, 0, 0,  1,  0,  3, ST_COEF_RDY);
        add_vec(0, 0, 1, 0, 0,   1, 0, 1,  1,  0,  3, ST_COEF_REQ);
        add_vec(0, 0, 0, 0, 0,   0, 0, 1,  1,  0,  3, ST_COEF_WAIT);
        add_vec(0, 0, 0, 1, 0,   0, 0, 1,  1,  0,  3, ST_COEF_RDY);
        add_vec(0, 0, 1, 0, 0,   1, 0, 2,  1,  0,  3, ST_COEF_REQ);
        add_vec(0, 0, 0, 0, 0,   0, 0, 2,  1,  0,  3, ST_COEF_WAIT);
        add_vec(0, 0, 0, 1, 1,   0, 0, 2,  1,  1,  4, ST_DONE);
        add_vec(0, 0, 0, 0, 0,   0, 0, 0,  0,  0,  4, ST_IDLE);
        add_vec(1, 1, 0, 0, 0,   0, 0, 0,  0,  0,  4, ST_IDLE);
        add_vec(1, 0, 0, 0, 0,   1, 1, 0,  1,  0,  0, ST_IMG_REQ);
        add_vec(0, 1, 0, 0, 0,   0, 0, 0,  0,  0,  0, ST_IDLE);

        do_reset();
        check("reset_outputs", out_vec(), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            go = tbl[i].go; abort = tbl[i].abort; node_ready = tbl[i].nr;
            sram_done = tbl[i].sd; read_nxt_byte = tbl[i].rnb;
            @(posedge clk); #1; cyc++;
            check($sformatf("vec%0d", i), out_vec(),
                  {1'b0, tbl[i].st, tbl[i].nci, tbl[i].sel, tbl[i].bsy, tbl[i].pd,
                   1'b0, tbl[i].bc, tbl[i].state});
        end

        // Basic pass: 5-cycle fetches with 4 bytes each.
        do_reset();
        load_pass(NUM_NODES);
        node_ready = 1'b1; go = 1'b1; t0 = cyc;
        cycle(); go = 1'b0;
        run_until_idle(200);
        check("basic_first_start", start_cyc[0], t0 + 1);
        check("basic_all_fetches", exp_q.size(), 0);
        check("basic_pass_done", pd_cnt, 1);
        check("basic_bytes", byte_count, 16);
        check("basic_busy_low_after_done", cyc, pd_cyc + 1);
        check("basic_no_err", timeout_err, 1'b0);

        // Backpressure after the image fetch.
        do_reset();
        load_pass(NUM_NODES);
        go = 1'b1;
        cycle(); go = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 50) begin cycle(); n++; end
        check("bp_image_done_seen", done_cnt, 1);
        s = 0;
        repeat (20) begin cycle(); if (start_sram) s++; end
        check("bp_no_start_while_low", s, 0);
        node_ready = 1'b1;
        cycle();
        check("bp_req_after_rise", {start_sram, n_coef_image, coef_select}, {1'b1, 1'b0, 7'd0});
        run_until_idle(200);
        check("bp_pass_done", pd_cnt, 1);
        check("bp_bytes", byte_count, 16);

        // Timeout on the k=1 fetch, then a restart from ERR.
        do_reset();
        load_pass(2);
        stall_at = 2; node_ready = 1'b1; go = 1'b1;
        cycle(); go = 1'b0;
        run_until_idle(200);
        check("to_err_cycle", cyc, start_cyc[2] + 1 + TIMEOUT);
        check("to_flag", timeout_err, 1'b1);
        check("to_state", dbg_state, ST_ERR);
        check("to_no_pass_done", pd_cnt, 0);
        check("to_bytes", byte_count, 8);
        load_pass(NUM_NODES);
        stall_at = -1; go = 1'b1;
        cycle(); go = 1'b0;
        check("to_restart", {timeout_err, byte_count, start_sram, n_coef_image},
              {1'b0, 16'd0, 1'b1, 1'b1});
        run_until_idle(200);
        check("to_restart_pass_done", pd_cnt, 1);
        check("to_restart_bytes", byte_count, 16);

        // Abort while waiting on the k=1 fetch.
        do_reset();
        load_pass(NUM_NODES);
        node_ready = 1'b1; go = 1'b1;
        cycle(); go = 1'b0;
        n = 0;
        while (fetch_no < 3 && n < 100) begin cycle(); n++; end
        check("ab_reached_k1", fetch_no, 3);
        cycle();
        abort = 1'b1; read_nxt_byte = 1'b0; sram_done = 1'b0;
        tm_active = 0; exp_q.delete();
        cycle(); abort = 1'b0;
        check("ab_idle", {busy, start_sram, pass_done, dbg_state}, {3'b000, ST_IDLE});
        check("ab_bytes", byte_count, 8);
        repeat (10) cycle();
        check("ab_no_more_starts", fetch_no, 3);
        check("ab_bytes_frozen", byte_count, 8);
        check("ab_no_pass_done", pd_cnt, 0);

        // Reset during COEF_REQ.
        do_reset();
        load_pass(NUM_NODES);
        node_ready = 1'b1; go = 1'b1;
        cycle(); go = 1'b0;
        n = 0;
        while (fetch_no < 2 && n < 100) begin cycle(); n++; end
        check("rst_reached_coef_req", {start_sram, fetch_no[3:0]}, {1'b1, 4'd2});
        rst = 1'b1; tm_active = 0; exp_q.delete();
        sram_done = 1'b0; read_nxt_byte = 1'b0;
        cycle(); rst = 1'b0;
        check("rst_mid_pass", out_vec(), 32'd0);

        // Randomized passes against the fetch-level model.
        rand_mode = 1; spurious_en = 1;
        for (int p = 0; p < 12; p++) begin
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_NODES)) : -1;
            load_pass(sa < 0 ? NUM_NODES : sa);
            stall_at = sa; go = 1'b1;
            cycle(); go = 1'b0;
            n = 0;
            while (busy && n < 600) begin
                node_ready = ($urandom_range(0, 3) != 0);
                go = ($urandom_range(0, 7) == 0);
                cycle();
                n++;
            end
            go = 1'b0;
            check($sformatf("rnd%0d_ends", p), busy, 1'b0);
            check($sformatf("rnd%0d_fetches", p), exp_q.size(), 0);
            check($sformatf("rnd%0d_pass_done", p), pd_cnt, (sa < 0) ? 1 : 0);
            check($sformatf("rnd%0d_terr", p), timeout_err, (sa < 0) ? 1'b0 : 1'b1);
            check($sformatf("rnd%0d_bytes", p), byte_count,
                  (bytes_sent > 65535) ? 65535 : bytes_sent);
            if (sa >= 0)
                check($sformatf("rnd%0d_err_cycle", p), cyc,
                      start_cyc[sa] + 1 + TIMEOUT + stall_bytes);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish before %0d ns", 500000);
        $fatal(1, "time limit");
    end

endmodule
